// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEPC     = 3'd1,
    S_MCAUSE   = 3'd2,
    S_MSTATUS  = 3'd3,
    S_MRET     = 3'd4,
    S_REDIRECT = 3'd5
  } state_t;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // mcause values
  localparam logic [31:0] CAUSE_IRQ    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;

  // stall vector bit positions
  localparam int unsigned STALL_PC      = 0;
  localparam int unsigned STALL_IF_ID   = 1;
  localparam int unsigned STALL_ID_EXE  = 2;
  localparam int unsigned STALL_EXE_MEM = 3;
  localparam int unsigned STALL_MEM_WB  = 4;
  localparam int unsigned STALL_W       = 5;

  // flush vector bit positions
  localparam int unsigned FLUSH_IF_ID   = 0;
  localparam int unsigned FLUSH_ID_EXE  = 1;
  localparam int unsigned FLUSH_EXE_MEM = 2;
  localparam int unsigned FLUSH_W       = 3;

  // mstatus field positions
  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  // Common stall/flush patterns
  localparam logic [STALL_W-1:0] STALL_NONE  = '0;
  localparam logic [STALL_W-1:0] STALL_FRONT =
    STALL_W'((1 << STALL_PC) | (1 << STALL_IF_ID));
  localparam logic [STALL_W-1:0] STALL_TO_EXE =
    STALL_W'((1 << STALL_PC) | (1 << STALL_IF_ID) | (1 << STALL_ID_EXE));

  localparam logic [FLUSH_W-1:0] FLUSH_NONE = '0;
  localparam logic [FLUSH_W-1:0] FLUSH_ALL  =
    FLUSH_W'((1 << FLUSH_IF_ID) | (1 << FLUSH_ID_EXE) | (1 << FLUSH_EXE_MEM));
  localparam logic [FLUSH_W-1:0] FLUSH_JUMP =
    FLUSH_W'((1 << FLUSH_IF_ID) | (1 << FLUSH_ID_EXE));
  localparam logic [FLUSH_W-1:0] FLUSH_EXE  = FLUSH_W'(1 << FLUSH_EXE_MEM);
  localparam logic [FLUSH_W-1:0] FLUSH_ID   = FLUSH_W'(1 << FLUSH_ID_EXE);

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges hazards, jumps, traps and mret into per-stage
// stall/flush controls and sequences the mepc/mcause/mstatus CSR writes.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      stallreq_id_i,
  input  logic                      stallreq_exe_i,
  input  logic                      exe_valid_i,
  input  logic [ADDR_WIDTH-1:0]     inst_addr_i,
  input  logic                      jump_req_i,
  input  logic [ADDR_WIDTH-1:0]     jump_addr_i,
  input  logic                      ecall_i,
  input  logic                      ebreak_i,
  input  logic                      mret_i,
  input  logic                      irq_i,
  input  logic [DATA_WIDTH-1:0]     csr_mstatus_i,
  input  logic [DATA_WIDTH-1:0]     csr_mtvec_i,
  input  logic [DATA_WIDTH-1:0]     csr_mepc_i,
  output logic [STALL_W-1:0]        stall_o,
  output logic [FLUSH_W-1:0]        flush_o,
  output logic                      redirect_o,
  output logic [ADDR_WIDTH-1:0]     redirect_addr_o,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic                      busy_o
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   epc_q, epc_d;
  logic [DATA_WIDTH-1:0]   cause_q, cause_d;
  logic [ADDR_WIDTH-1:0]   target_q, target_d;

  logic                    irq_take;
  logic                    trap_take;
  logic [DATA_WIDTH-1:0]   mstatus_trap;
  logic [DATA_WIDTH-1:0]   mstatus_mret;

  // Interrupt is only taken on a real instruction that is not mid-operation.
  assign irq_take  = irq_i & csr_mstatus_i[MSTATUS_MIE] & exe_valid_i & ~stallreq_exe_i;
  assign trap_take = irq_take | ecall_i | ebreak_i;

  // mstatus images for trap entry and mret
  always_comb begin
    mstatus_trap = csr_mstatus_i;
    mstatus_trap[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
    mstatus_trap[MSTATUS_MIE]  = 1'b0;
    mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    mstatus_mret = csr_mstatus_i;
    mstatus_mret[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
    mstatus_mret[MSTATUS_MPIE] = 1'b1;
  end

  // State and latched trap context
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      epc_q    <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
    end
  end

  // Next-state and stall/flush/CSR decode
  always_comb begin
    state_d         = state_q;
    epc_d           = epc_q;
    cause_d         = cause_q;
    target_d        = target_q;
    stall_o         = STALL_NONE;
    flush_o         = FLUSH_NONE;
    redirect_o      = 1'b0;
    redirect_addr_o = '0;
    csr_we_o        = 1'b0;
    csr_waddr_o     = '0;
    csr_wdata_o     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (trap_take) begin
          epc_d   = inst_addr_i;
          cause_d = irq_take ? DATA_WIDTH'(CAUSE_IRQ) :
                    ecall_i  ? DATA_WIDTH'(CAUSE_ECALL) : DATA_WIDTH'(CAUSE_EBREAK);
          flush_o = FLUSH_ALL;
          state_d = S_MEPC;
        end else if (mret_i) begin
          flush_o = FLUSH_ALL;
          state_d = S_MRET;
        end else if (jump_req_i) begin
          redirect_o      = 1'b1;
          redirect_addr_o = jump_addr_i;
          flush_o         = FLUSH_JUMP;
        end else if (stallreq_exe_i) begin
          stall_o = STALL_TO_EXE;
          flush_o = FLUSH_EXE;
        end else if (stallreq_id_i) begin
          stall_o = STALL_FRONT;
          flush_o = FLUSH_ID;
        end
      end
      S_MEPC: begin
        stall_o     = STALL_FRONT;
        flush_o     = FLUSH_ALL;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MEPC);
        csr_wdata_o = DATA_WIDTH'(epc_q);
        state_d     = S_MCAUSE;
      end
      S_MCAUSE: begin
        stall_o     = STALL_FRONT;
        flush_o     = FLUSH_ALL;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MCAUSE);
        csr_wdata_o = cause_q;
        state_d     = S_MSTATUS;
      end
      S_MSTATUS: begin
        stall_o     = STALL_FRONT;
        flush_o     = FLUSH_ALL;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MSTATUS);
        csr_wdata_o = mstatus_trap;
        target_d    = ADDR_WIDTH'(csr_mtvec_i) & ~ADDR_WIDTH'(3);
        state_d     = S_REDIRECT;
      end
      S_MRET: begin
        stall_o     = STALL_FRONT;
        flush_o     = FLUSH_ALL;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MSTATUS);
        csr_wdata_o = mstatus_mret;
        target_d    = ADDR_WIDTH'(csr_mepc_i);
        state_d     = S_REDIRECT;
      end
      S_REDIRECT: begin
        stall_o         = STALL_FRONT;
        flush_o         = FLUSH_ALL;
        redirect_o      = 1'b1;
        redirect_addr_o = target_q;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs read zero for as long as reset is held.
    if (!rst_n_i) begin
      stall_o         = STALL_NONE;
      flush_o         = FLUSH_NONE;
      redirect_o      = 1'b0;
      redirect_addr_o = '0;
      csr_we_o        = 1'b0;
      csr_waddr_o     = '0;
      csr_wdata_o     = '0;
    end
  end

  assign busy_o = rst_n_i & (state_q != S_IDLE);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: decode table plus trap/mret sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallreq_id, stallreq_exe, exe_valid;
  logic [31:0] inst_addr;
  logic        jump_req;
  logic [31:0] jump_addr;
  logic        ecall, ebreak, mret, irq;
  logic [31:0] csr_mstatus, csr_mtvec, csr_mepc;
  logic [4:0]  stall;
  logic [2:0]  flush;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        busy;

  pipe_ctrl dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .stallreq_id_i  (stallreq_id),
    .stallreq_exe_i (stallreq_exe),
    .exe_valid_i    (exe_valid),
    .inst_addr_i    (inst_addr),
    .jump_req_i     (jump_req),
    .jump_addr_i    (jump_addr),
    .ecall_i        (ecall),
    .ebreak_i       (ebreak),
    .mret_i         (mret),
    .irq_i          (irq),
    .csr_mstatus_i  (csr_mstatus),
    .csr_mtvec_i    (csr_mtvec),
    .csr_mepc_i     (csr_mepc),
    .stall_o        (stall),
    .flush_o        (flush),
    .redirect_o     (redirect),
    .redirect_addr_o(redirect_addr),
    .csr_we_o       (csr_we),
    .csr_waddr_o    (csr_waddr),
    .csr_wdata_o    (csr_wdata),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  stall;
    logic [2:0]  flush;
    logic        redir;
    logic [31:0] raddr;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        busy;
  } exp_t;

  typedef struct {
    logic        sid;
    logic        sexe;
    logic        jmp;
    logic [31:0] jaddr;
    logic        irq;
    logic        mie;
    exp_t        exp;
  } vec_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk(logic [4:0] s, logic [2:0] f, logic r, logic [31:0] ra,
                              logic w, logic [11:0] wa, logic [31:0] wd, logic b);
    exp_t e;
    e.stall = s; e.flush = f; e.redir = r; e.raddr = ra;
    e.we = w; e.waddr = wa; e.wdata = wd; e.busy = b;
    return e;
  endfunction

  // Compare the oldest expectation against the DUT mid-cycle, then advance.
  task automatic tick(input string name);
    exp_t e, a;
    @(negedge clk);
    a = {stall, flush, redirect, redirect_addr, csr_we, csr_waddr, csr_wdata, busy};
    total++;
    if (expq.size() == 0) begin
      bad++;
      $display("FAIL %s: no expectation queued", name);
    end else begin
      e = expq.pop_front();
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got stall=%b flush=%b redir=%b raddr=%h we=%b waddr=%h wdata=%h busy=%b; want stall=%b flush=%b redir=%b raddr=%h we=%b waddr=%h wdata=%h busy=%b",
                 name, a.stall, a.flush, a.redir, a.raddr, a.we, a.waddr, a.wdata, a.busy,
                 e.stall, e.flush, e.redir, e.raddr, e.we, e.waddr, e.wdata, e.busy);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    stallreq_id = 0; stallreq_exe = 0; jump_req = 0; jump_addr = 0;
    ecall = 0; ebreak = 0; mret = 0; irq = 0;
  endtask

  // Trap entry from cycle T (inputs already driven) through return to idle.
  task automatic trap_seq(input string name, input logic [31:0] epc, input logic [31:0] cause,
                          input logic [31:0] mstat_exp, input logic [31:0] handler);
    expq.push_back(mk(5'b00000, 3'b111, 0, 0, 0, 0, 0, 0));
    tick({name, "_T0"});
    clear_events();
    irq = 1;  // must be ignored while busy
    expq.push_back(mk(5'b00011, 3'b111, 0, 0, 1, 12'h341, epc, 1));
    tick({name, "_mepc"});
    ecall = 1;
    expq.push_back(mk(5'b00011, 3'b111, 0, 0, 1, 12'h342, cause, 1));
    tick({name, "_mcause"});
    jump_req = 1; jump_addr = 32'h0000_0ABC;
    expq.push_back(mk(5'b00011, 3'b111, 0, 0, 1, 12'h300, mstat_exp, 1));
    tick({name, "_mstatus"});
    stallreq_exe = 1;
    expq.push_back(mk(5'b00011, 3'b111, 1, handler, 0, 0, 0, 1));
    tick({name, "_redirect"});
    clear_events();
    expq.push_back(mk(5'b00000, 3'b000, 0, 0, 0, 0, 0, 0));
    tick({name, "_idle"});
  endtask

  vec_t vecs[8];

  initial begin
    rst_n = 0;
    clear_events();
    exe_valid = 1;
    inst_addr = 0;
    csr_mstatus = 0; csr_mtvec = 0; csr_mepc = 0;
    stallreq_id = 1;  // outputs must still read zero under reset
    expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tick("reset");
    rst_n = 1;
    stallreq_id = 0;

    // Idle decode table
    vecs[0] = '{0, 0, 0, 32'h0,  0, 0, mk(5'b00000, 3'b000, 0, 0, 0, 0, 0, 0)};
    vecs[1] = '{1, 0, 0, 32'h0,  0, 0, mk(5'b00011, 3'b010, 0, 0, 0, 0, 0, 0)};
    vecs[2] = '{0, 1, 0, 32'h0,  0, 0, mk(5'b00111, 3'b100, 0, 0, 0, 0, 0, 0)};
    vecs[3] = '{1, 1, 0, 32'h0,  0, 0, mk(5'b00111, 3'b100, 0, 0, 0, 0, 0, 0)};
    vecs[4] = '{1, 0, 1, 32'h80, 0, 0, mk(5'b00000, 3'b011, 1, 32'h80, 0, 0, 0, 0)};
    vecs[5] = '{0, 1, 1, 32'h44, 0, 0, mk(5'b00000, 3'b011, 1, 32'h44, 0, 0, 0, 0)};
    vecs[6] = '{0, 0, 0, 32'h0,  1, 0, mk(5'b00000, 3'b000, 0, 0, 0, 0, 0, 0)};
    vecs[7] = '{0, 1, 0, 32'h0,  1, 1, mk(5'b00111, 3'b100, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 8; i++) begin
      stallreq_id  = vecs[i].sid;
      stallreq_exe = vecs[i].sexe;
      jump_req     = vecs[i].jmp;
      jump_addr    = vecs[i].jaddr;
      irq          = vecs[i].irq;
      csr_mstatus  = vecs[i].mie ? 32'h8 : 32'h0;
      expq.push_back(vecs[i].exp);
      tick($sformatf("vec%0d", i));
    end
    clear_events();
    expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tick("after_vecs");

    // ecall
    inst_addr = 32'h100; csr_mtvec = 32'h204; csr_mstatus = 32'h8; ecall = 1;
    trap_seq("ecall", 32'h100, 32'd11, 32'h1880, 32'h204);

    // ebreak with MIE clear, mtvec low bits masked
    inst_addr = 32'h3C0; csr_mtvec = 32'h1003; csr_mstatus = 32'h0; ebreak = 1;
    trap_seq("ebreak", 32'h3C0, 32'd3, 32'h1800, 32'h1000);

    // irq beats a simultaneous jump; mepc is the jump instruction's PC
    inst_addr = 32'h200; csr_mtvec = 32'h204; csr_mstatus = 32'h8;
    irq = 1; jump_req = 1; jump_addr = 32'h300;
    trap_seq("irq_jump", 32'h200, 32'h8000_000B, 32'h1880, 32'h204);

    // irq beats mret
    inst_addr = 32'h244; csr_mstatus = 32'h8; irq = 1; mret = 1;
    trap_seq("irq_mret", 32'h244, 32'h8000_000B, 32'h1880, 32'h204);

    // mret
    csr_mstatus = 32'h80; csr_mepc = 32'h104; mret = 1;
    expq.push_back(mk(5'b00000, 3'b111, 0, 0, 0, 0, 0, 0));
    tick("mret_T0");
    clear_events();
    expq.push_back(mk(5'b00011, 3'b111, 0, 0, 1, 12'h300, 32'h88, 1));
    tick("mret_mstatus");
    expq.push_back(mk(5'b00011, 3'b111, 1, 32'h104, 0, 0, 0, 1));
    tick("mret_redirect");
    expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tick("mret_idle");

    // Reset during S_MCAUSE aborts the sequence
    inst_addr = 32'h500; csr_mstatus = 32'h8; ecall = 1;
    expq.push_back(mk(5'b00000, 3'b111, 0, 0, 0, 0, 0, 0));
    tick("rst_T0");
    clear_events();
    expq.push_back(mk(5'b00011, 3'b111, 0, 0, 1, 12'h341, 32'h500, 1));
    tick("rst_mepc");
    rst_n = 0;
    expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tick("rst_in_mcause");
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      tick($sformatf("rst_after%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline controller for the 5-stage RV32 core. It sits beside the IF/ID/EXE/MEM/WB registers and the CSR file. It merges stall requests, branch/jump redirects, synchronous exceptions (ecall/ebreak), mret and the external interrupt into per-stage stall/flush controls. It also runs the multi-cycle trap-entry/exit sequence that writes mepc/mcause/mstatus through the CSR file's single write port.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC width
- DATA_WIDTH, 32, CSR data width
- CSR_ADDR_WIDTH, 12, CSR address width

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  reset, asynchronous, active-low
- stallreq_id_i  in  1  load-use hazard from ID
- stallreq_exe_i  in  1  multi-cycle op busy in EXE
- exe_valid_i  in  1  EXE holds a real (non-bubble) instruction
- inst_addr_i  in  ADDR_WIDTH  PC of the EXE instruction
- jump_req_i  in  1  taken branch/jump resolved in EXE
- jump_addr_i  in  ADDR_WIDTH  jump target
- ecall_i, ebreak_i, mret_i  in  1 each  decoded in EXE, mutually exclusive
- irq_i  in  1  external interrupt, level
- csr_mstatus_i, csr_mtvec_i, csr_mepc_i  in  DATA_WIDTH  current CSR values
- stall_o  out  5  hold: [0] pc, [1] if_id, [2] id_exe, [3] exe_mem, [4] mem_wb
- flush_o  out  3  bubble-insert: [0] if_id, [1] id_exe, [2] exe_mem
- redirect_o  out  1  load PC with redirect_addr_o
- redirect_addr_o  out  ADDR_WIDTH  new PC
- csr_we_o  out  1  CSR write strobe
- csr_waddr_o  out  CSR_ADDR_WIDTH  CSR write address
- csr_wdata_o  out  DATA_WIDTH  CSR write data
- busy_o  out  1  FSM not in S_IDLE

## Operation
- States: S_IDLE, S_MEPC, S_MCAUSE, S_MSTATUS, S_MRET, S_REDIRECT.
- Trap trigger (S_IDLE only), in priority order:
  - irq: `irq_i & csr_mstatus_i[3] & exe_valid_i & !stallreq_exe_i`; cause 0x8000000B.
  - ecall: cause 11.
  - ebreak: cause 3.
  - On any trigger: latch epc = inst_addr_i and latch the cause; go to S_MEPC.
- mret in S_IDLE: go to S_MRET.
- Trigger cycle: flush_o = 3'b111, stall_o = 0. The EXE instruction is killed; for irq it re-executes after return.
- S_MEPC: write 0x341 = epc. Next S_MCAUSE.
- S_MCAUSE: write 0x342 = cause. Next S_MSTATUS.
- S_MSTATUS: write 0x300 = csr_mstatus_i with MPIE[7] ← MIE[3], MIE ← 0, MPP[12:11] ← 2'b11. Next S_REDIRECT, target {csr_mtvec_i[31:2], 2'b00} (direct mode only).
- S_MRET: write 0x300 with MIE ← MPIE, MPIE ← 1. Next S_REDIRECT, target csr_mepc_i.
- S_REDIRECT: redirect_o = 1, flush_o = 3'b111. Next S_IDLE.
- While busy_o: stall_o = 5'b00011, flush_o = 3'b111. MEM/WB keep draining older instructions.
- S_IDLE, no trigger, combinational priority:
  - jump_req_i: redirect_o = 1 to jump_addr_i, flush_o = 3'b011.
  - else stallreq_exe_i: stall_o = 5'b00111, flush_o = 3'b100.
  - else stallreq_id_i: stall_o = 5'b00011, flush_o = 3'b010.
  - else all zero.
- Simultaneous events:
  - Trigger beats jump_req_i; the jump is re-executed after return.
  - jump_req_i beats both stall requests.
  - mret plus irq: irq wins, epc = PC of the mret.
- Events arriving while busy_o are ignored.

## Timing
- Reset (async, any state): state S_IDLE; all outputs 0.
- Trap entry, trigger at cycle T:
  - T+1 mepc write, T+2 mcause, T+3 mstatus.
  - T+4 redirect. First handler fetch at T+5.
- mret at T: T+1 mstatus write, T+2 redirect.
- Reset asserted mid-sequence aborts it. Partially written CSRs are not rolled back; the CSR file resets independently.
- csr_we_o is high for exactly one cycle per write and never in S_IDLE or S_REDIRECT.
- Stall/flush/redirect in S_IDLE are combinational from inputs. FSM-driven outputs are decoded from registered state only.

## Structure
- Add to defines.v:
  - CSR addresses: CSR_MSTATUS 0x300, CSR_MTVEC 0x305, CSR_MEPC 0x341, CSR_MCAUSE 0x342.
  - Cause codes.
  - Stall/flush bit indices.
  - State encodings.
- Single module, no sub-modules. The FSM and the stall/flush decode share state, so splitting them adds no value.

## Test plan
- stallreq_id_i = 1 for 1 cycle -> stall_o = 00011, flush_o = 010 that cycle, then 0.
- jump_req_i = 1 with jump_addr_i = 0x80 while stallreq_id_i = 1 -> redirect_o = 1 to 0x80, flush_o = 011, stall_o = 0.
- ecall at inst_addr_i = 0x100, mtvec = 0x204, mstatus = 0x8:
  - T+1: 0x341 = 0x100. T+2: 0x342 = 11. T+3: 0x300 = 0x1880.
  - T+4: redirect to 0x204.
- mret with mstatus = 0x80, mepc = 0x104 -> T+1: 0x300 = 0x88; T+2: redirect to 0x104.
- irq_i with MIE = 1 and jump_req_i in the same cycle -> trap taken, mcause = 0x8000000B, mepc = jump PC, no jump redirect.
- rst_n_i low during S_MCAUSE -> all outputs 0 immediately. After release, busy_o = 0 and no further csr_we_o.
